// File: rtl/pll_clk_monitor_pkg.sv
// Shared definitions for the PLL clock monitor: FSM encoding, default parameters
// and the elaboration-time tolerance bound helper.
package pll_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 50000;
  localparam int unsigned DEF_EXP_COUNT   = 25000;
  localparam int unsigned DEF_TOL         = 2;
  localparam int unsigned DEF_CNT_W       = 20;

  // Lower tolerance bound clamped at zero so it never wraps.
  function automatic int unsigned tol_lo(input int unsigned exp_count, input int unsigned tol);
    return (exp_count > tol) ? (exp_count - tol) : 0;
  endfunction

endpackage

// File: rtl/pll_clk_monitor_edge_sync.sv
// Three-flop synchronizer for the monitored clock plus a rising-edge pulse
// taken between the second and third stage.
module pll_clk_monitor_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  logic s0;
  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= async_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise_c = s1 & ~s2;

endmodule

// File: rtl/pll_clk_monitor.sv
// Gated edge counter for a PLL output clock: counts synchronized rising edges over
// GATE_CYCLES sys_clk cycles and reports count, tolerance, stuck and saturation flags.
module pll_clk_monitor
  import pll_clk_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned EXP_COUNT   = DEF_EXP_COUNT,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_mon,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             freq_ok,
  output logic             stuck,
  output logic             sat
);

  localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0]   LO_BOUND  = (CNT_W+1)'(tol_lo(EXP_COUNT, TOL));
  localparam logic [CNT_W:0]   HI_BOUND  = (CNT_W+1)'(EXP_COUNT + TOL);
  localparam logic [CNT_W-1:0] ACC_MAX   = '1;

  mon_state_t        state;
  mon_state_t        state_nxt;
  logic              arm_c;
  logic              rise_c;
  logic              gate_last_c;
  logic              window_end_c;
  logic              in_tol_c;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_nxt;
  logic              sat_acc;
  logic              sat_nxt;

  pll_clk_monitor_edge_sync u_edge_sync (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .async_in (clk_mon),
    .rise_c   (rise_c)
  );

  assign gate_last_c  = (gate_cnt == GATE_LAST);
  assign window_end_c = (state == MEASURE) && gate_last_c;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; arm_c marks every entry into MEASURE so the datapath restarts.
  always_comb begin
    state_nxt = state;
    arm_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = MEASURE;
          arm_c     = 1'b1;
        end
      end
      MEASURE: begin
        if (gate_last_c) state_nxt = DONE;
      end
      DONE: begin
        if (continuous) begin
          state_nxt = MEASURE;
          arm_c     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating accumulate of this cycle's edge; sticks at all-ones and flags the lost edge.
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_acc;
    if (rise_c) begin
      if (acc == ACC_MAX) sat_nxt = 1'b1;
      else                acc_nxt = acc + CNT_W'(1);
    end
  end

  assign in_tol_c = ({1'b0, acc_nxt} >= LO_BOUND) && ({1'b0, acc_nxt} <= HI_BOUND);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gate_cnt <= '0;
      acc      <= '0;
      sat_acc  <= 1'b0;
    end else if (arm_c) begin
      gate_cnt <= '0;
      acc      <= '0;
      sat_acc  <= 1'b0;
    end else if (state == MEASURE) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      acc      <= acc_nxt;
      sat_acc  <= sat_nxt;
    end
  end

  // Results are registered from the final MEASURE cycle so they appear with done.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      edge_cnt <= '0;
      freq_ok  <= 1'b0;
      stuck    <= 1'b0;
      sat      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= window_end_c;
      if (window_end_c) begin
        edge_cnt <= acc_nxt;
        freq_ok  <= in_tol_c;
        stuck    <= (acc_nxt == '0);
        sat      <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Bench for pll_clk_monitor: a vector table, randomized frequencies against an
// ideal-count model, and directed continuous/ignore/reset/saturation sequences.
module tb_pll_clk_monitor;

  localparam int G      = 1000;
  localparam int SYS_P  = 20;
  localparam int TOL    = 2;
  localparam int EXP_A  = 200;
  localparam int CW_A   = 20;
  localparam int EXP_B  = 20;
  localparam int CW_B   = 6;
  localparam int LO_A   = EXP_A - TOL;
  localparam int HI_A   = EXP_A + TOL;

  logic sys_clk    = 1'b0;
  logic sys_rst    = 1'b1;
  logic clk_mon    = 1'b0;
  logic start_a    = 1'b0;
  logic start_b    = 1'b0;
  logic continuous = 1'b0;

  logic            busy_a, done_a, ok_a, stuck_a, sat_a;
  logic [CW_A-1:0] cnt_a;
  logic            busy_b, done_b, ok_b, stuck_b, sat_b;
  logic [CW_B-1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  int   mon_half = 0;
  logic mon_hold = 1'b0;

  pll_clk_monitor #(.GATE_CYCLES(G), .EXP_COUNT(EXP_A), .TOL(TOL), .CNT_W(CW_A)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_mon(clk_mon), .start(start_a),
    .continuous(continuous), .busy(busy_a), .done(done_a), .edge_cnt(cnt_a),
    .freq_ok(ok_a), .stuck(stuck_a), .sat(sat_a));

  pll_clk_monitor #(.GATE_CYCLES(G), .EXP_COUNT(EXP_B), .TOL(TOL), .CNT_W(CW_B)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_mon(clk_mon), .start(start_b),
    .continuous(continuous), .busy(busy_b), .done(done_b), .edge_cnt(cnt_b),
    .freq_ok(ok_b), .stuck(stuck_b), .sat(sat_b));

  always #(SYS_P/2) sys_clk = ~sys_clk;

  // Monitored clock: toggles only at 3 or 8 units past a sys_clk edge (halves are multiples of 5).
  initial begin
    @(posedge sys_clk);
    #3;
    forever begin
      if (mon_half == 0) begin
        clk_mon = mon_hold;
        @(posedge sys_clk);
        #3;
      end else begin
        #(mon_half);
        clk_mon = ~clk_mon;
      end
    end
  end

  initial begin
    #(60000 * SYS_P);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_mon(input int half, input logic hold);
    mon_half = half;
    mon_hold = hold;
    repeat (30) tick();
  endtask

  // Returns the number of cycles until done is seen, or -1 if the budget runs out.
  task automatic wait_done(input bit b, input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((b ? done_b : done_a) === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  // Pulse start in cycle 0 and return the cycle index in which done appears.
  task automatic run_window(input bit b, output int k);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(b, G + 10, k);
    if (k > 0) k++;
  endtask

  task automatic chk_result(input bit b, input string tag, input int k, input int lo, input int hi,
                            input int ok, input int stk, input int st);
    chk({tag, ".done_cycle"}, k, G + 1);
    chk_rng({tag, ".edge_cnt"}, b ? int'(cnt_b) : int'(cnt_a), lo, hi);
    chk({tag, ".freq_ok"}, b ? int'(ok_b) : int'(ok_a), ok);
    chk({tag, ".stuck"}, b ? int'(stuck_b) : int'(stuck_a), stk);
    chk({tag, ".sat"}, b ? int'(sat_b) : int'(sat_a), st);
  endtask

  task automatic chk_idle_after(input bit b, input string tag);
    tick();
    chk({tag, ".done_after"}, b ? int'(done_b) : int'(done_a), 0);
    chk({tag, ".busy_after"}, b ? int'(busy_b) : int'(busy_a), 0);
  endtask

  // Ideal edge count over the gate window; a real count differs from it by less than one.
  function automatic real ideal_count(input int half);
    return real'(G * SYS_P) / real'(2 * half);
  endfunction

  typedef struct {
    int   half;
    logic hold;
    int   cnt_lo;
    int   cnt_hi;
    int   ok;
    int   stuck;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   halves[7];
    int   k, k2, k3, ndone;
    real  ideal;

    vecs[0] = '{50,  1'b0, 199, 201, 1, 0};   // 10 MHz, in tolerance
    vecs[1] = '{40,  1'b0, 249, 251, 0, 0};   // 12.5 MHz, too fast
    vecs[2] = '{0,   1'b0, 0,   0,   0, 1};   // held low
    vecs[3] = '{0,   1'b1, 0,   0,   0, 1};   // held high
    halves  = '{40, 45, 50, 55, 60, 80, 100};

    repeat (3) tick();
    chk("rst.busy", int'(busy_a), 0);
    chk("rst.done", int'(done_a), 0);
    chk("rst.edge_cnt", int'(cnt_a), 0);
    chk("rst.freq_ok", int'(ok_a), 0);
    chk("rst.stuck", int'(stuck_a), 0);
    chk("rst.sat", int'(sat_a), 0);
    sys_rst = 1'b0;
    tick();
    chk("post_rst.busy", int'(busy_a), 0);

    for (int i = 0; i < 4; i++) begin
      set_mon(vecs[i].half, vecs[i].hold);
      run_window(1'b0, k);
      chk_result(1'b0, $sformatf("vec%0d", i), k, vecs[i].cnt_lo, vecs[i].cnt_hi,
                 vecs[i].ok, vecs[i].stuck, 0);
      chk_idle_after(1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      int half;
      half = halves[$urandom_range(0, 6)];
      set_mon(half, 1'b0);
      repeat ($urandom_range(0, 9)) tick();
      ideal = ideal_count(half);
      run_window(1'b0, k);
      chk_result(1'b0, $sformatf("rnd%0d_h%0d", i, half), k,
                 int'($ceil(ideal)) - 1, int'($floor(ideal)) + 1,
                 (ideal >= real'(LO_A) && ideal <= real'(HI_A)) ? 1 : 0, 0, 0);
    end

    // Continuous mode: back-to-back windows, then drop continuous mid-window.
    set_mon(50, 1'b0);
    continuous = 1'b1;
    run_window(1'b0, k);
    chk("cont.first_done", k, G + 1);
    chk_rng("cont.cnt1", int'(cnt_a), 199, 201);
    wait_done(1'b0, G + 10, k2);
    chk("cont.period2", k2, G + 1);
    chk_rng("cont.cnt2", int'(cnt_a), 199, 201);
    repeat (5) tick();
    continuous = 1'b0;
    wait_done(1'b0, G + 10, k3);
    chk("cont.period3", k3 + 5, G + 1);
    chk_rng("cont.cnt3", int'(cnt_a), 199, 201);
    chk_idle_after(1'b0, "cont");

    // start pulses mid-window are ignored.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = -1;
    for (int c = 2; c <= G + 5; c++) begin
      tick();
      start_a = (c == 300 || c == 700) ? 1'b1 : 1'b0;
      if (done_a === 1'b1 && k < 0) k = c;
    end
    start_a = 1'b0;
    chk("ignore.done_cycle", k, G + 1);
    chk("ignore.busy_after", int'(busy_a), 0);

    // Reset mid-window clears everything at once and suppresses done.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (499) tick();
    #3;
    sys_rst = 1'b1;
    #1;
    chk("midrst.busy", int'(busy_a), 0);
    chk("midrst.edge_cnt", int'(cnt_a), 0);
    chk("midrst.freq_ok", int'(ok_a), 0);
    chk("midrst.done", int'(done_a), 0);
    repeat (2) tick();
    sys_rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < G + 100; c++) begin
      tick();
      if (done_a === 1'b1) ndone++;
    end
    chk("midrst.no_done", ndone, 0);
    chk("midrst.busy_later", int'(busy_a), 0);
    run_window(1'b0, k);
    chk_result(1'b0, "fresh", k, 199, 201, 1, 0, 0);

    // Narrow counter saturates at 10 MHz, then a 1 MHz window is in tolerance.
    set_mon(50, 1'b0);
    run_window(1'b1, k);
    chk_result(1'b1, "sat", k, 63, 63, 0, 0, 1);
    chk_idle_after(1'b1, "sat");
    set_mon(500, 1'b0);
    run_window(1'b1, k);
    chk_result(1'b1, "slow", k, 19, 21, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
